// File: rtl/reset_pulse_sequencer.sv
// Multi-channel edge-to-pulse reset request sequencer: synchronises requests, latches edges as
// pending and serves them one at a time by fixed priority, with an inter-pulse holdoff gap.
module reset_pulse_sequencer #(
    parameter int unsigned             NUM_CH                = 3,
    parameter int unsigned             CNT_W                 = 8,
    parameter logic [NUM_CH*CNT_W-1:0] PULSE_LEN             = {8'd32, 8'd2, 8'd6},
    parameter logic [2*NUM_CH-1:0]     EDGE_TYPE             = {3{2'b01}},
    parameter logic [NUM_CH-1:0]       IGNORE_RST_WHILE_BUSY = 3'b111,
    parameter int unsigned             HOLDOFF               = 4,
    parameter int unsigned             SYNC_STAGES           = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] signal_in,
    output logic [NUM_CH-1:0] pulse_out,
    output logic              busy,
    output logic [NUM_CH-1:0] pending
);
    localparam int unsigned SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam int unsigned ARM_N  = SYNC_N + 1;
    localparam int unsigned ARM_W  = $clog2(ARM_N + 1);
    localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {IDLE, PULSE, HOLD} state_t;

    logic [SYNC_N-1:0][NUM_CH-1:0] sync_q;
    logic [NUM_CH-1:0]             hist_q;
    logic [NUM_CH-1:0]             edge_q;
    logic [NUM_CH-1:0]             edge_det;
    logic [ARM_W-1:0]              arm_cnt;
    logic                          armed;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic              skip_hold_q, skip_hold_d;
    logic              grant;
    logic [CH_W-1:0]   grant_ch;
    logic [CNT_W-1:0]  grant_len;
    logic [NUM_CH-1:0] grant_vec;
    logic [CNT_W-1:0]  cnt_dec;
    logic              cnt_last;
    logic              keep_pulse;

    assign armed      = (arm_cnt == ARM_W'(ARM_N));
    assign cnt_last   = (cnt_q <= CNT_W'(1));
    assign cnt_dec    = cnt_last ? '0 : cnt_q - CNT_W'(1);
    assign keep_pulse = (state_q == PULSE) && IGNORE_RST_WHILE_BUSY[ch_q];
    assign grant_vec  = grant ? (NUM_CH'(1) << grant_ch) : '0;

    // Edge qualification: bit 0 of each pair enables rising, bit 1 enables falling
    always_comb begin
        edge_det = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            edge_det[i] = (EDGE_TYPE[2*i]   &  sync_q[SYNC_N-1][i] & ~hist_q[i])
                        | (EDGE_TYPE[2*i+1] & ~sync_q[SYNC_N-1][i] &  hist_q[i]);
        end
    end

    // Synchroniser, history and edge register; arm counter masks edges right after reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q  <= '0;
            hist_q  <= '0;
            edge_q  <= '0;
            arm_cnt <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_N-2:0], signal_in};
            hist_q <= sync_q[SYNC_N-1];
            edge_q <= armed ? edge_det : '0;
            if (!armed) begin
                arm_cnt <= arm_cnt + ARM_W'(1);
            end
        end
    end

    // Lowest pending index wins; a zero length is served as one cycle
    always_comb begin
        grant_ch  = '0;
        grant_len = '0;
        for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
            if (pending[i]) begin
                grant_ch  = CH_W'(i);
                grant_len = PULSE_LEN[i*CNT_W +: CNT_W];
            end
        end
        if (grant_len == '0) begin
            grant_len = CNT_W'(1);
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ch_d        = ch_q;
        skip_hold_d = skip_hold_q;
        grant       = 1'b0;
        if (!rst_n) begin
            // Only reached with a protected pulse: finish it, then skip the holdoff
            state_d     = cnt_last ? IDLE : PULSE;
            cnt_d       = cnt_dec;
            skip_hold_d = 1'b1;
        end else begin
            case (state_q)
                IDLE: grant = |pending;
                PULSE: begin
                    if (!cnt_last) begin
                        cnt_d = cnt_dec;
                    end else if (HOLDOFF > 0 && !skip_hold_q) begin
                        state_d = HOLD;
                        cnt_d   = CNT_W'(HOLDOFF);
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
                HOLD: begin
                    if (!cnt_last) begin
                        cnt_d = cnt_dec;
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        grant   = |pending;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
            if (grant) begin
                state_d     = PULSE;
                cnt_d       = grant_len;
                ch_d        = grant_ch;
                skip_hold_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n && !keep_pulse) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            ch_q        <= '0;
            skip_hold_q <= 1'b0;
            pulse_out   <= '0;
            busy        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ch_q        <= ch_d;
            skip_hold_q <= skip_hold_d;
            pulse_out   <= (state_d == PULSE) ? (NUM_CH'(1) << ch_d) : '0;
            busy        <= (state_d != IDLE);
        end
    end

    // An edge on the channel being pulsed (or just granted) is dropped
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~grant_vec) | (edge_q & ~pulse_out & ~grant_vec);
        end
    end

endmodule
